// File: rtl/lcd_write_engine_pkg.sv
// Shared definitions for the LCD write engine: FSM state encoding,
// HD44780 command bytes that need the long execution wait, and default timing.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EHIGH = 3'd2,
      EHOLD = 3'd3,
      WAIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   // Return-home ignores bit 0, so 0x03 is also a home command.
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   localparam int unsigned DEF_E_HIGH_CYC    = 1;
   localparam int unsigned DEF_WAIT_CYC      = 1;
   localparam int unsigned DEF_LONG_WAIT_CYC = 2;

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_write_engine.sv
// HD44780 bus write engine: one request -> setup, E pulse, hold, execution wait, wr_finish.
// Define LCD_4BIT_EN for 4-bit bus mode (two nibble transfers per byte on lcd_db[7:4]).
module lcd_write_engine
   import lcd_pkg::*;
#(
   parameter int unsigned E_HIGH_CYC    = DEF_E_HIGH_CYC,
   parameter int unsigned WAIT_CYC      = DEF_WAIT_CYC,
   parameter int unsigned LONG_WAIT_CYC = DEF_LONG_WAIT_CYC
)(
   input  logic       clk_1ms,
   input  logic       reset,
   input  logic       wr_enable,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       wr_finish,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_db
);

   state_t     state, state_d;
   logic [7:0] cnt, cnt_d;
   logic       wr_en_q;
   logic       start;
   logic       latch;
   logic       rs_q;
   logic [7:0] data_q;
   logic [7:0] wait_load;
   logic       lcd_e_d, lcd_rs_d, busy_d, wr_finish_d;
   logic [7:0] lcd_db_d;
`ifdef LCD_4BIT_EN
   logic       nib, nib_d;
`endif

   assign start  = wr_enable & ~wr_en_q;
   assign lcd_rw = 1'b0;

   assign wait_load = is_long_cmd(rs_q, data_q) ? 8'(LONG_WAIT_CYC - 1) : 8'(WAIT_CYC - 1);

   // Outputs are computed for the next state and registered with it.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      lcd_e_d     = lcd_e;
      lcd_rs_d    = lcd_rs;
      lcd_db_d    = lcd_db;
      busy_d      = busy;
      wr_finish_d = 1'b0;
      latch       = 1'b0;
`ifdef LCD_4BIT_EN
      nib_d       = nib;
`endif
      case (state)
         IDLE: begin
            busy_d  = 1'b0;
            lcd_e_d = 1'b0;
            if (start) begin
               latch    = 1'b1;
               lcd_rs_d = wr_rs;
`ifdef LCD_4BIT_EN
               lcd_db_d = {wr_data[7:4], 4'h0};
               nib_d    = 1'b0;
`else
               lcd_db_d = wr_data;
`endif
               busy_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            lcd_e_d = 1'b1;
            cnt_d   = 8'(E_HIGH_CYC - 1);
            state_d = EHIGH;
         end
         EHIGH: begin
            if (cnt == 8'd0) begin
               lcd_e_d = 1'b0;
               state_d = EHOLD;
            end else begin
               cnt_d = cnt - 8'd1;
            end
         end
         EHOLD: begin
            cnt_d   = wait_load;
            state_d = WAIT;
`ifdef LCD_4BIT_EN
            // First nibble done: present the low nibble and repeat the strobe.
            if (!nib) begin
               nib_d    = 1'b1;
               lcd_db_d = {data_q[3:0], 4'h0};
               cnt_d    = cnt;
               state_d  = SETUP;
            end
`endif
         end
         WAIT: begin
            if (cnt == 8'd0) begin
               wr_finish_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt - 8'd1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            lcd_e_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1ms or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         wr_en_q   <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_db    <= 8'h00;
         busy      <= 1'b0;
         wr_finish <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         wr_en_q   <= wr_enable;
         lcd_e     <= lcd_e_d;
         lcd_rs    <= lcd_rs_d;
         lcd_db    <= lcd_db_d;
         busy      <= busy_d;
         wr_finish <= wr_finish_d;
      end
   end

`ifdef LCD_4BIT_EN
   always_ff @(posedge clk_1ms or negedge reset) begin
      if (!reset) nib <= 1'b0;
      else        nib <= nib_d;
   end
`endif

   // Request payload; only meaningful while busy, so it carries no reset.
   always_ff @(posedge clk_1ms) begin
      if (latch) begin
         rs_q   <= wr_rs;
         data_q <= wr_data;
      end
   end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Scoreboard bench for lcd_write_engine; honours LCD_4BIT_EN when defined.
module tb_lcd_write_engine;

   localparam int E  = 1;
   localparam int W  = 1;
   localparam int LW = 2;
`ifdef LCD_4BIT_EN
   localparam int NIB = 2;
`else
   localparam int NIB = 1;
`endif

   logic       clk_1ms = 1'b0;
   logic       reset = 1'b0;
   logic       wr_enable = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_finish, busy, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_db;

   lcd_write_engine #(.E_HIGH_CYC(E), .WAIT_CYC(W), .LONG_WAIT_CYC(LW)) dut (
      .clk_1ms(clk_1ms), .reset(reset), .wr_enable(wr_enable), .wr_rs(wr_rs),
      .wr_data(wr_data), .wr_finish(wr_finish), .busy(busy), .lcd_e(lcd_e),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
   );

   always #5 clk_1ms = ~clk_1ms;

   int cyc = 0;
   always @(posedge clk_1ms) cyc <= cyc + 1;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         k;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic int exp_wait(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : W;
   endfunction

   function automatic logic [7:0] exp_db(input logic [7:0] d, input int idx);
`ifdef LCD_4BIT_EN
      return (idx == 0) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
`else
      return (idx == 0) ? d : d;
`endif
   endfunction

   // Monitor: samples on the falling edge, checks strobes and finish against the scoreboard.
   int   e_rises = 0;
   int   e_high = 0;
   logic prev_e = 1'b0;
   always @(negedge clk_1ms) begin
      exp_t x;
      if (!reset) begin
         e_rises = 0;
         e_high  = 0;
         prev_e  = 1'b0;
      end else begin
         if (lcd_e) e_high++;
         if (lcd_e && !prev_e) begin
            if (sb.size() == 0) check_eq("spurious_e", 1, 0);
            else begin
               x = sb[0];
               check_eq("e_rise_cyc", cyc, x.k + 1 + e_rises * (2 + E));
               check_eq("e_rs", lcd_rs, x.rs);
               check_eq("e_db", lcd_db, exp_db(x.data, e_rises));
               check_eq("e_busy", busy, 1);
            end
            e_rises++;
         end
         if (wr_finish) begin
            if (sb.size() == 0) check_eq("spurious_finish", 1, 0);
            else begin
               x = sb.pop_front();
               check_eq("fin_cyc", cyc,
                        x.k + 2 + E + exp_wait(x.rs, x.data) + (NIB - 1) * (2 + E));
               check_eq("fin_e_pulses", e_rises, NIB);
               check_eq("fin_e_width", e_high, NIB * E);
               check_eq("fin_busy", busy, 1);
               check_eq("fin_e_low", lcd_e, 0);
            end
            e_rises = 0;
            e_high  = 0;
         end
         prev_e = lcd_e;
      end
   end

   // One write: wr_enable high for 'hold' edges, optional one-cycle re-rise
   // sampled at edge k+rerise+1 (must be >= hold).
   task automatic do_write(input logic rs, input logic [7:0] d, input int hold, input int rerise);
      exp_t x;
      int   j;
      @(negedge clk_1ms);
      wr_enable = 1'b1;
      wr_rs     = rs;
      wr_data   = d;
      x.rs = rs;
      x.data = d;
      x.k = cyc + 1;
      sb.push_back(x);
      for (j = 0; j < 40; j++) begin
         @(negedge clk_1ms);
         wr_enable = (j + 1 < hold) || (rerise != 0 && j == rerise);
         #2;
         if (sb.size() == 0 && j > rerise && j + 1 >= hold) break;
      end
      wr_enable = 1'b0;
      if (sb.size() != 0) begin
         check_eq("timeout", 0, 1);
         sb.delete();
      end
      @(negedge clk_1ms);
      #2;
      check_eq("post_finish", wr_finish, 0);
      check_eq("post_busy", busy, 0);
      check_eq("post_rs_held", lcd_rs, rs);
      check_eq("post_db_held", lcd_db, exp_db(d, NIB - 1));
      repeat (3) @(negedge clk_1ms);
   endtask

   initial begin
      repeat (3) @(posedge clk_1ms);
      @(negedge clk_1ms);
      check_eq("rst_finish", wr_finish, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_e", lcd_e, 0);
      check_eq("rst_rs", lcd_rs, 0);
      check_eq("rst_db", lcd_db, 8'h00);
      check_eq("rst_rw", lcd_rw, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk_1ms);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_finish", wr_finish, 0);

      do_write(1'b1, 8'h41, 1, 0);
      do_write(1'b0, 8'h01, 1, 0);
      do_write(1'b0, 8'h38, 1, 0);
      do_write(1'b0, 8'h02, 1, 0);
      do_write(1'b0, 8'h03, 1, 0);
      do_write(1'b1, 8'h01, 1, 0);
      do_write(1'b0, 8'h00, 1, 0);
      do_write(1'b0, 8'h04, 1, 0);
      do_write(1'b1, 8'h55, 10, 0);
      do_write(1'b0, 8'h38, 1, 1);
      do_write(1'b1, 8'h42, 1, 2 + E + W + (NIB - 1) * (2 + E));
      do_write(1'b1, 8'hA5, 1, 0);

      // Abort a clear command while it is in its execution wait.
      @(negedge clk_1ms);
      wr_enable = 1'b1;
      wr_rs     = 1'b0;
      wr_data   = 8'h01;
      begin
         exp_t x;
         x.rs = 1'b0;
         x.data = 8'h01;
         x.k = cyc + 1;
         sb.push_back(x);
      end
      @(negedge clk_1ms);
      wr_enable = 1'b0;
      repeat (3) @(negedge clk_1ms);
      reset = 1'b0;
      #1;
      check_eq("abort_e", lcd_e, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_finish", wr_finish, 0);
      sb.delete();
      repeat (2) @(negedge clk_1ms);
      reset = 1'b1;
      repeat (6) @(negedge clk_1ms);
      check_eq("abort_idle_busy", busy, 0);
      do_write(1'b1, 8'h7E, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

endmodule
